// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU ops, MDU ops, operand
// forwarding selects and the multiply/divide sequencer states.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  // Any op with bit 2 set is a divide flavour; bit 0 set means unsigned.
  typedef enum logic [2:0] {
    MDU_MUL   = 3'b000,
    MDU_MULHU = 3'b001,
    MDU_DIV   = 3'b100,
    MDU_DIVU  = 3'b101,
    MDU_REM   = 3'b110,
    MDU_REMU  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step
// per cycle for XLEN cycles, then a sign fix-up cycle that hands the
// result to the EX/MEM register when it has room.
module ex_mdu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            out_free,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] dividend;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            neg_r;
  logic            b_zero;

  logic            sgn_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] nhi;
  logic [XLEN-1:0] nlo;

  // Signed divides work on magnitudes; the signs are restored in FIN.
  always_comb begin
    sgn_in = op[2] & ~op[0];
    a_mag  = (sgn_in && a[XLEN-1]) ? -a : a;
    b_mag  = (sgn_in && b[XLEN-1]) ? -b : b;
  end

  // One iteration step: {hi,lo} is the product accumulator for multiply,
  // or the partial remainder / quotient pair for divide.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, dvs};
    if (op_q[2]) begin
      nhi = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
      nlo = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      nhi = mul_sum[XLEN:1];
      nlo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Result selection with sign fix-up; the unsigned divide-by-zero corner
  // falls out of the restoring algorithm, the signed one needs an override.
  always_comb begin
    case (op_q)
      MDU_MULHU: result = hi;
      MDU_DIV:   result = b_zero ? '1 : (neg_q ? -lo : lo);
      MDU_DIVU:  result = lo;
      MDU_REM:   result = b_zero ? dividend : (neg_r ? -hi : hi);
      MDU_REMU:  result = hi;
      default:   result = lo;
    endcase
  end

  assign idle = (state == IDLE);
  assign done = (state == FIN) && out_free && !flush;

  // Sequencer: latch operands on start, iterate XLEN steps, wait in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      dividend <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            dividend <= a;
            b_zero   <= (b == '0);
            neg_q    <= sgn_in & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r    <= sgn_in & a[XLEN-1];
            hi       <= '0;
            lo       <= a_mag;
            dvs      <= b_mag;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= FIN;
          end
        end
        FIN: begin
          if (flush || out_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MDU and
// the EX/MEM output register with valid/ready handshaking.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 64,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic             alusrc_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic             mdu_en_i,
  input  logic [2:0]       mdu_op_i,
  input  logic             memread_i,
  input  logic             memwrite_i,
  input  logic             memtoreg_i,
  input  logic             regwrite_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_rst_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [4:0]       rd_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             memtoreg_o,
  output logic             regwrite_o
);

  localparam int SHW = $clog2(XLEN);

  fwd_sel_e        sel1;
  fwd_sel_e        sel2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_mdu;
  logic            out_free;
  logic            accept;
  logic            alu_load;
  logic            mdu_start;
  logic            mdu_idle;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  logic [4:0]      pend_rd;
  logic [3:0]      pend_ctl;
  logic [XLEN-1:0] pend_wdata;

  logic            unused_imm;
  assign unused_imm = ^imm_i[IMM_W-1:XLEN];

  assign is_mdu    = MDU_EN && mdu_en_i;
  assign out_free  = !out_valid_o || out_ready_i;
  assign in_ready_o = !rst && mdu_idle && out_free;
  assign accept    = in_valid_i && in_ready_o && !flush_i;
  assign alu_load  = accept && !is_mdu;
  assign mdu_start = accept && is_mdu;

  // Forwarding select: the younger EX/MEM result beats MEM/WB; x0 never forwards.
  always_comb begin
    sel1 = FWD_REG;
    sel2 = FWD_REG;
    if (out_valid_o && regwrite_o && rd_o != '0 && rd_o == rs1_i)
      sel1 = FWD_EXMEM;
    else if (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == rs1_i)
      sel1 = FWD_MEMWB;
    if (out_valid_o && regwrite_o && rd_o != '0 && rd_o == rs2_i)
      sel2 = FWD_EXMEM;
    else if (mem_regwrite_i && mem_rd_i != '0 && mem_rd_i == rs2_i)
      sel2 = FWD_MEMWB;
  end

  // Operand muxes; store data always follows the forwarded rs2.
  always_comb begin
    case (sel1)
      FWD_EXMEM: fwd1 = alu_rst_o;
      FWD_MEMWB: fwd1 = wb_data_i;
      default:   fwd1 = op1_i;
    endcase
    case (sel2)
      FWD_EXMEM: fwd2 = alu_rst_o;
      FWD_MEMWB: fwd2 = wb_data_i;
      default:   fwd2 = op2_i;
    endcase
    opb   = alusrc_i ? imm_i[XLEN-1:0] : fwd2;
    shamt = opb[SHW-1:0];
  end

  // Single-cycle ALU.
  always_comb begin
    case (alu_ctrl_i)
      ALU_AND:  alu_res = fwd1 & opb;
      ALU_OR:   alu_res = fwd1 | opb;
      ALU_ADD:  alu_res = fwd1 + opb;
      ALU_XOR:  alu_res = fwd1 ^ opb;
      ALU_SLL:  alu_res = fwd1 << shamt;
      ALU_SRL:  alu_res = fwd1 >> shamt;
      ALU_SUB:  alu_res = fwd1 - opb;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd1) < $signed(opb)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd1 < opb};
      ALU_SRA:  alu_res = $unsigned($signed(fwd1) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  ex_mdu #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .start    (mdu_start),
    .flush    (flush_i),
    .out_free (out_free),
    .op       (mdu_op_i),
    .a        (fwd1),
    .b        (fwd2),
    .idle     (mdu_idle),
    .done     (mdu_done),
    .result   (mdu_res)
  );

  // Controls of an in-flight MDU instruction wait here until FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rd    <= '0;
      pend_ctl   <= '0;
      pend_wdata <= '0;
    end else if (mdu_start) begin
      pend_rd    <= rd_i;
      pend_ctl   <= {memread_i, memwrite_i, memtoreg_i, regwrite_i};
      pend_wdata <= fwd2;
    end
  end

  // EX/MEM register: a load may coincide with a drain; otherwise a drain clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      alu_rst_o   <= '0;
      mem_wdata_o <= '0;
      rd_o        <= '0;
      memread_o   <= 1'b0;
      memwrite_o  <= 1'b0;
      memtoreg_o  <= 1'b0;
      regwrite_o  <= 1'b0;
    end else if (alu_load) begin
      out_valid_o <= 1'b1;
      alu_rst_o   <= alu_res;
      mem_wdata_o <= fwd2;
      rd_o        <= rd_i;
      memread_o   <= memread_i;
      memwrite_o  <= memwrite_i;
      memtoreg_o  <= memtoreg_i;
      regwrite_o  <= regwrite_i;
    end else if (mdu_done) begin
      out_valid_o <= 1'b1;
      alu_rst_o   <= mdu_res;
      mem_wdata_o <= pend_wdata;
      rd_o        <= pend_rd;
      {memread_o, memwrite_o, memtoreg_o, regwrite_o} <= pend_ctl;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
